// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and parity-type constants
// used by both the transmit and receive sides.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_if.sv
// Bundle between a serial-line source (master) and the UART receiver (slave),
// including the receiver's state for observation.
interface uart_rx_if #(
    parameter int Width = 8
);
    import uart_pkg::*;

    // Data_Valid, Parity_Error and Stop_Error are single-cycle strobes with no
    // back-pressure; P_Data is stable from a Data_Valid until the next one.
    logic             RX_in;
    logic             Parity_En;
    logic             Parity_Typ;
    logic [Width-1:0] P_Data;
    logic             Data_Valid;
    logic             Parity_Error;
    logic             Stop_Error;
    logic             Busy;
    rx_state_t        dbg_state;

    modport master (
        output RX_in, Parity_En, Parity_Typ,
        input  P_Data, Data_Valid, Parity_Error, Stop_Error, Busy, dbg_state
    );

    modport slave (
        input  RX_in, Parity_En, Parity_Typ,
        output P_Data, Data_Valid, Parity_Error, Stop_Error, Busy, dbg_state
    );

endinterface

// File: rtl/uart_rx_sampler.sv
// Line synchroniser plus mid-bit sampling; bit_o is the decided bit value,
// meaningful at the decision point. Macro: UART_RX_MAJORITY_VOTE_EN.
module uart_rx_sampler #(
    parameter int Prescale = 8,
    parameter int CntW     = 3
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            rx_i,
    input  logic [CntW-1:0] edge_cnt_i,
    output logic            rx_s_o,
    output logic            bit_o
);

    localparam logic [CntW-1:0] MidEdge = CntW'(Prescale / 2);

    logic sync1_q, sync2_q;
    logic mid_q;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [CntW-1:0] EarlyEdge = CntW'(Prescale / 2 - 1);
    logic early_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            mid_q   <= 1'b1;
`ifdef UART_RX_MAJORITY_VOTE_EN
            early_q <= 1'b1;
`endif
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            if (edge_cnt_i == MidEdge) mid_q <= sync2_q;
`ifdef UART_RX_MAJORITY_VOTE_EN
            if (edge_cnt_i == EarlyEdge) early_q <= sync2_q;
`endif
        end
    end

    assign rx_s_o = sync2_q;

    // The third sample is the live synchronised line at the decision edge.
`ifdef UART_RX_MAJORITY_VOTE_EN
    assign bit_o = (early_q & mid_q) | (early_q & sync2_q) | (mid_q & sync2_q);
`else
    assign bit_o = mid_q;
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start / Width data (LSB first) / optional parity / stop.
// Majority-vote bit decision is enabled by UART_RX_MAJORITY_VOTE_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int Width    = 8,
    parameter int Prescale = 8
) (
    input  logic     Clk,
    input  logic     Rst,
    uart_rx_if.slave rx_if
);

    localparam int CntW = $clog2(Prescale);
    localparam int BitW = (Width > 1) ? $clog2(Width) : 1;
    localparam logic [CntW-1:0] LastEdge = CntW'(Prescale - 1);
    localparam logic [CntW-1:0] DecEdge  = CntW'(Prescale / 2 + 1);
    localparam logic [BitW-1:0] LastBit  = BitW'(Width - 1);

    rx_state_t        state_q;
    logic [CntW-1:0]  edge_cnt_q;
    logic [BitW-1:0]  bit_cnt_q;
    logic             armed_q;
    logic             par_en_q, par_typ_q, mismatch_q;
    logic [Width-1:0] shift_q, p_data_q;
    logic             dv_q, pe_q, se_q;

    logic rx_s, samp_bit, at_dec, bit_end;

    uart_rx_sampler #(
        .Prescale (Prescale),
        .CntW     (CntW)
    ) u_sampler (
        .clk_i      (Clk),
        .rst_i      (Rst),
        .rx_i       (rx_if.RX_in),
        .edge_cnt_i (edge_cnt_q),
        .rx_s_o     (rx_s),
        .bit_o      (samp_bit)
    );

    assign at_dec  = (edge_cnt_q == DecEdge);
    assign bit_end = (edge_cnt_q == LastEdge);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= IDLE;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            armed_q    <= 1'b0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            mismatch_q <= 1'b0;
            shift_q    <= '0;
            p_data_q   <= '0;
            dv_q       <= 1'b0;
            pe_q       <= 1'b0;
            se_q       <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            pe_q <= 1'b0;
            se_q <= 1'b0;
            if (state_q != IDLE) edge_cnt_q <= bit_end ? '0 : edge_cnt_q + 1'b1;
            case (state_q)
                IDLE: begin
                    edge_cnt_q <= '0;
                    bit_cnt_q  <= '0;
                    if (rx_s) begin
                        armed_q <= 1'b1;
                    end else if (armed_q) begin
                        state_q    <= START;
                        par_en_q   <= rx_if.Parity_En;
                        par_typ_q  <= rx_if.Parity_Typ;
                        mismatch_q <= 1'b0;
                    end
                end
                START: begin
                    if (at_dec && samp_bit) state_q <= IDLE;
                    else if (bit_end)       state_q <= DATA;
                end
                DATA: begin
                    if (at_dec) shift_q[bit_cnt_q] <= samp_bit;
                    if (bit_end) begin
                        if (bit_cnt_q == LastBit) state_q <= par_en_q ? PARITY : STOP;
                        else                      bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                PARITY: begin
                    if (at_dec)  mismatch_q <= samp_bit ^ (^shift_q) ^ par_typ_q;
                    if (bit_end) state_q <= STOP;
                end
                STOP: begin
                    // Leave at mid-stop so the next start edge can be caught early.
                    if (at_dec) begin
                        state_q <= IDLE;
                        if (samp_bit) begin
                            if (mismatch_q) begin
                                pe_q <= 1'b1;
                            end else begin
                                dv_q     <= 1'b1;
                                p_data_q <= shift_q;
                            end
                        end else begin
                            se_q    <= 1'b1;
                            pe_q    <= mismatch_q;
                            armed_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_if.P_Data       = p_data_q;
    assign rx_if.Data_Valid   = dv_q;
    assign rx_if.Parity_Error = pe_q;
    assign rx_if.Stop_Error   = se_q;
    assign rx_if.Busy         = (state_q != IDLE);
    assign rx_if.dbg_state    = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx (Width=8, Prescale=8) with an event scoreboard.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int P = 8;
  localparam int W = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  uart_rx_if #(.Width(8)) rx_if ();

  uart_rx #(.Width(8), .Prescale(P)) dut (
    .Clk   (clk),
    .Rst   (rst),
    .rx_if (rx_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // expected events: {stop_err, parity_err, valid, p_data}
  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  logic [7:0]   last_good = 8'h00;
  int           n_checks = 0;
  int           n_errors = 0;
  int           start_cyc = 0;
  rx_state_t    prev_state = IDLE;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_if.RX_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    last_good = 8'h00;
  endtask

  task automatic drive_bit(input logic b, input int n);
    rx_if.RX_in = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                            input logic flip, input logic stop_bit);
    logic mism;
    logic [W-1:0] ev;
    mism = pen & flip;
    if (stop_bit) begin
      if (mism) ev = {3'b010, last_good};
      else begin
        ev = {3'b001, d};
        last_good = d;
      end
    end else begin
      ev = {1'b1, mism, 1'b0, last_good};
    end
    exp_q.push_back(ev);
    lat_q.push_back(P * (9 + int'(pen)) + P / 2 + 2);
    rx_if.Parity_En  = pen;
    rx_if.Parity_Typ = ptyp;
    drive_bit(1'b0, P);
    for (int i = 0; i < 8; i++) drive_bit(d[i], P);
    if (pen) drive_bit((^d) ^ ptyp ^ flip, P);
    drive_bit(stop_bit, P);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    logic [W-1:0] obs;
    if (!rst) begin
      if (rx_if.dbg_state == START && prev_state == IDLE) start_cyc = cyc;
      prev_state = rx_if.dbg_state;
      if (rx_if.Data_Valid || rx_if.Parity_Error || rx_if.Stop_Error) begin
        obs = {rx_if.Stop_Error, rx_if.Parity_Error, rx_if.Data_Valid, rx_if.P_Data};
        if (exp_q.size() == 0) begin
          check("unexpected_event", obs, '0);
        end else begin
          check("event", obs, exp_q.pop_front());
          check("latency", cyc - start_cyc, lat_q.pop_front());
        end
      end
    end else begin
      prev_state = IDLE;
    end
  end

  initial begin
    logic seen_busy;
    rx_if.RX_in      = 1'b1;
    rx_if.Parity_En  = 1'b0;
    rx_if.Parity_Typ = PARITY_EVEN;
    do_reset();
    @(negedge clk);
    check("rst_p_data", rx_if.P_Data, 0);
    check("rst_valid", rx_if.Data_Valid, 0);
    check("rst_perr", rx_if.Parity_Error, 0);
    check("rst_serr", rx_if.Stop_Error, 0);
    check("rst_busy", rx_if.Busy, 0);
    check("rst_state", rx_if.dbg_state, IDLE);
    drive_bit(1'b1, 2 * P);

    send_frame(8'hA5, 1'b0, PARITY_EVEN, 1'b0, 1'b1);
    drive_bit(1'b1, 2 * P);
    send_frame(8'h3C, 1'b1, PARITY_EVEN, 1'b0, 1'b1);
    drive_bit(1'b1, 2 * P);
    send_frame(8'h3C, 1'b1, PARITY_EVEN, 1'b1, 1'b1);
    drive_bit(1'b1, 2 * P);
    send_frame(8'h81, 1'b1, PARITY_ODD, 1'b0, 1'b1);
    drive_bit(1'b1, 2 * P);
    send_frame(8'h81, 1'b1, PARITY_ODD, 1'b0, 1'b0);
    drain();

    seen_busy = 1'b0;
    rx_if.RX_in = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rx_if.Busy) seen_busy = 1'b1;
    end
    check("break_no_retrigger", seen_busy, 0);
    drive_bit(1'b1, 2 * P);
    send_frame(8'h42, 1'b0, PARITY_EVEN, 1'b0, 1'b1);
    drive_bit(1'b1, 2 * P);
    drain();

    drive_bit(1'b0, 2);
    drive_bit(1'b1, P);
    check("glitch_busy", rx_if.Busy, 0);
    check("glitch_state", rx_if.dbg_state, IDLE);
    drive_bit(1'b1, P);

    send_frame(8'h00, 1'b0, PARITY_EVEN, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, PARITY_EVEN, 1'b0, 1'b1);
    drive_bit(1'b1, 2 * P);
    drain();

    for (int k = 0; k < 4; k++) begin
      logic [7:0] rd;
      rd = 8'($urandom_range(0, 255));
      send_frame(rd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      drive_bit(1'b1, $urandom_range(1, 3) * P);
    end
    drain();

    rx_if.Parity_En = 1'b0;
    drive_bit(1'b0, P);
    for (int i = 0; i < 4; i++) drive_bit(i[0], P);
    drive_bit(1'b1, P / 2);
    check("mid_frame_state", rx_if.dbg_state, DATA);
    rst = 1'b1;
    rx_if.RX_in = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_good = 8'h00;
    check("mid_rst_p_data", rx_if.P_Data, 0);
    check("mid_rst_busy", rx_if.Busy, 0);
    check("mid_rst_state", rx_if.dbg_state, IDLE);
    check("mid_rst_valid", rx_if.Data_Valid, 0);
    drive_bit(1'b1, 2 * P);
    send_frame(8'h5A, 1'b0, PARITY_EVEN, 1'b0, 1'b1);
    drive_bit(1'b1, 2 * P);
    drain();

    check("leftover_events", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got 0x1 expected 0x0");
    $fatal(1);
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive counterpart of the UART transmitter: recovers frames of start bit, `Width` data bits LSB first, optional parity bit and one stop bit from the serial line. The block runs on a single oversampling clock at `Prescale` × bit rate, samples each bit near its centre, checks parity and stop, and presents the data word with a one-cycle valid strobe. It shares the frame format and the parity controls (`Parity_En`, `Parity_Typ`) with the transmit side.

## Interface
- `Width`, 8, data bits per frame.
- `Prescale`, 8, clock cycles per bit; even and ≥ 4.
- `Clk`  in  1  oversampling clock; all logic is on the rising edge.
- `Rst`  in  1  reset, synchronous, active-high.
- `RX_in`  in  1  serial line; idle high; asynchronous to `Clk`.
- `Parity_En`  in  1  1 means a parity bit follows the data.
- `Parity_Typ`  in  1  0 selects even parity, 1 selects odd.
- `P_Data`  out  Width  received word; holds its value until the next good frame.
- `Data_Valid`  out  1  one-cycle pulse when a frame with good parity and good stop is received.
- `Parity_Error`  out  1  one-cycle pulse on a parity mismatch.
- `Stop_Error`  out  1  one-cycle pulse when the stop bit is sampled as 0.
- `Busy`  out  1  high in every state except IDLE.

## Operation
- `RX_in` passes through a 2-FF synchroniser, reset value 1; the result is `rx_s`.
- Counters:
  - `edge_cnt` runs 0..Prescale-1 and wraps at each bit boundary.
  - `bit_cnt` runs 0..Width-1.
- Sampling:
  - Samples are taken at `edge_cnt` = Prescale/2-1, Prescale/2 and Prescale/2+1.
  - The bit decision is made at `edge_cnt` = Prescale/2+1 (the decision point).
  - See Configuration for how the samples are combined.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - An `armed` flag is set whenever `rx_s`=1.
  - If `armed` and `rx_s`=0: go to START. That cycle is `edge_cnt`=0. `Parity_En` and `Parity_Typ` are latched here.
- START: at the decision point:
  - Sample 1 is a glitch: return to IDLE with no outputs.
  - Sample 0: stay in START until the bit period ends, then go to DATA.
- DATA:
  - Each decided bit is shifted into bit position `bit_cnt`, LSB first.
  - After bit Width-1 the bit period ends and the FSM moves to PARITY if parity was latched enabled, otherwise to STOP.
- PARITY:
  - The decided bit is compared with XOR(data) XOR latched `Parity_Typ`.
  - The result is held in a mismatch flag; the FSM moves to STOP at the end of the bit period.
- STOP: at the decision point, return to IDLE immediately. This early return allows resynchronisation on the next start edge. Next-cycle outputs:
  - Stop sampled 1, no mismatch: `P_Data` loaded and `Data_Valid`=1.
  - Stop sampled 1, mismatch: `Parity_Error`=1; no `Data_Valid`, `P_Data` unchanged.
  - Stop sampled 0: `Stop_Error`=1 and `armed` is cleared; no `Data_Valid`. `Parity_Error` is also pulsed if there is a mismatch.
- A cleared `armed` flag prevents a held-low line (break) from retriggering the receiver.
- Reset applies in any state, including mid-frame:
  - State IDLE; counters 0; `armed` 0; synchroniser 1.
  - All outputs 0, including `P_Data`.
  - Any partial frame is discarded.

## Timing
- Pin to `rx_s`: 2 cycles.
- Define N = 1 + Width + Parity_En.
- `Data_Valid` asserts N·Prescale + Prescale/2 + 2 cycles after the START-entry cycle.
- Width=8, Prescale=8: 78 cycles without parity, 86 with parity.
- Errors have the same latency as `Data_Valid`. All pulses last exactly one cycle.
- The earliest accepted next start edge is the cycle after the return to IDLE.

## Configuration
- `UART_RX_MAJORITY_VOTE_EN` defined: the bit value is the 2-of-3 majority of the three samples.
- Not defined: the bit value is the single sample at Prescale/2. The decision point and all latencies are unchanged.

## Structure
- Package `uart_pkg` holds:
  - the state enum `rx_state_t`;
  - constants `PARITY_EVEN`=0 and `PARITY_ODD`=1, shared with the transmitter.
- Sub-module `uart_rx_sampler` contains the synchroniser, the sample registers and the vote/decision. It outputs `rx_s` and the decided bit.

## Test plan
- Send 0xA5, no parity, Prescale=8 → `P_Data`=0xA5 and `Data_Valid` pulses once, 78 cycles after START entry.
- Send 0x3C with even parity, parity bit 0 → valid; then 0x3C with parity bit 1 → `Parity_Error` pulse, no valid, `P_Data` still 0x3C.
- Send 0x81 with odd parity, parity bit 1 → valid; the same frame with the stop bit 0 → `Stop_Error` pulse. Hold the line low for 40 cycles → no retrigger; release high and send 0x42 → valid with 0x42.
- Drive `RX_in` low for 2 cycles, then high → no START past the decision point, no outputs, `Busy` low within Prescale cycles.
- Send two frames back-to-back (0x00, then 0xFF) with the next start immediately after a full stop bit → two valid pulses with the correct data.
- Assert `Rst` for 1 cycle in DATA at bit 4 → all outputs 0, IDLE; the next clean 0x5A frame is received correctly.
